// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the decoded control-bundle pipeline: depth limit,
// bundle field positions used by the decoders/datapath, and stage operations.
package ctrl_pipe_pkg;

  localparam int unsigned CTRL_PIPE_MAX_STAGES = 8;
  localparam int unsigned CTRL_W_DEFAULT       = 16;

  // Field positions inside one control bundle
  localparam int unsigned CTRL_MEMTOREG   = 0;
  localparam int unsigned CTRL_MEMWRITE   = 1;
  localparam int unsigned CTRL_ALUSRC     = 2;
  localparam int unsigned CTRL_REGDST     = 3;
  localparam int unsigned CTRL_REGWRITE   = 4;
  localparam int unsigned CTRL_ALUCTL_LSB = 5;
  localparam int unsigned CTRL_ALUCTL_MSB = 7;

  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_HOLD  = 2'd1,
    OP_CLEAR = 2'd2
  } stageOpT;

  // Flush beats hold, hold beats bubble insertion, otherwise load.
  function automatic stageOpT stageOp(input logic flush, input logic hold,
                                      input logic bubble);
    if (flush)  return OP_CLEAR;
    if (hold)   return OP_HOLD;
    if (bubble) return OP_CLEAR;
    return OP_LOAD;
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline stage: a W-bit control bundle plus valid bit with async reset
// and flush / hold / bubble / load selection.
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] srcCtrl,
  input  logic         srcValid,
  output logic [W-1:0] ctrl,
  output logic         valid
);

  stageOpT op;

  always_comb begin
    op = stageOp(flush, hold, bubble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl  <= '0;
      valid <= 1'b0;
    end else begin
      case (op)
        OP_CLEAR: begin
          ctrl  <= '0;
          valid <= 1'b0;
        end
        OP_HOLD: begin
          ctrl  <= ctrl;
          valid <= valid;
        end
        default: begin
          ctrl  <= srcCtrl;
          valid <= srcValid;
        end
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from decode through STAGES downstream stages with
// per-stage stall/flush. Optional stall counter: CTRL_PIPE_STALLCNT_EN.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          d_ctrl,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  output logic [STAGES*W-1:0]   q_ctrl,
  output logic [STAGES-1:0]     q_valid
`ifdef CTRL_PIPE_STALLCNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  logic [STAGES-1:0] hold;

  // Hold chain: a stall anywhere at or below a stage freezes it.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int unsigned k = 1; k < STAGES; k++) begin
      hold[STAGES-1-k] = stall[STAGES-1-k] | hold[STAGES-k];
    end
  end

  assign d_ready = ~hold[0];

  genvar g;
  for (g = 0; g < STAGES; g++) begin : gStage
    logic [W-1:0] srcCtrl;
    logic         srcValid;
    logic         bubble;

    if (g == 0) begin : gHead
      assign srcCtrl  = d_ctrl;
      assign srcValid = d_valid;
      assign bubble   = 1'b0;
    end else begin : gBody
      assign srcCtrl  = q_ctrl[(g-1)*W +: W];
      assign srcValid = q_valid[g-1];
      // A flushed-and-held upstream stage hands its old contents on rather
      // than a bubble, so the bundle moves down once and is not lost.
      assign bubble   = hold[g-1] & ~flush[g-1];
    end

    ctrl_pipe_stage #(.W(W)) uStage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[g]),
      .hold     (hold[g]),
      .bubble   (bubble),
      .srcCtrl  (srcCtrl),
      .srcValid (srcValid),
      .ctrl     (q_ctrl[g*W +: W]),
      .valid    (q_valid[g])
    );
  end

`ifdef CTRL_PIPE_STALLCNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if ((|stall) && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign stall_cnt = stallCnt;
`endif

endmodule
